// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// Define BCD_SIGNED_EN to treat binary as two's complement and report the sign separately.
module bcd_seq_converter #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      binary,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  ovf
);
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] sh_q, sh_d, sh_n, mag;
  logic [4*DIGITS-1:0] dig_q, dig_d, dig_n, adj, bcd_q, bcd_d;
  logic ovw_q, ovw_d, sgw_q, sgw_d, sign_q, sign_d, ovf_q, ovf_d, sgn, top;
`ifdef BCD_SIGNED_EN
  assign sgn = binary[BIN_W-1];
  assign mag = sgn ? BIN_W'(0) - binary : binary;
`else
  assign sgn = 1'b0;
  assign mag = binary;
`endif
  always_comb begin
    adj = dig_q;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k+:4] = dig_q[4*k+:4] >= 4'd5 ? dig_q[4*k+:4] + 4'd3 : dig_q[4*k+:4];
  end
  // top is the bit pushed out of the most significant digit: any 1 there means overflow
  assign {top, dig_n, sh_n} = {adj, sh_q, 1'b0};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    dig_d   = dig_q;
    ovw_d   = ovw_q;
    sgw_d   = sgw_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SHIFT;
        sh_d    = mag;
        dig_d   = '0;
        ovw_d   = 1'b0;
        sgw_d   = sgn;
        cnt_d   = CW'(BIN_W);
      end
      SHIFT: if (cnt_q == '0) begin
        state_d = DONE;
        bcd_d   = dig_q;
        ovf_d   = ovw_q;
        sign_d  = sgw_q;
      end else begin
        dig_d = dig_n;
        sh_d  = sh_n;
        ovw_d = ovw_q | top;
        cnt_d = cnt_q - CW'(1);
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dig_q   <= '0;
      ovw_q   <= 1'b0;
      sgw_q   <= 1'b0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dig_q   <= dig_d;
      ovw_q   <= ovw_d;
      sgw_q   <= sgw_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign bcd       = bcd_q;
  assign sign      = sign_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb_bcd_seq_converter: drives a 5-digit and a 3-digit converter in lockstep against an arithmetic model.
module tb_bcd_seq_converter;
  localparam int LAT = 17;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [15:0] binary = 0;
  logic in_ready, out_valid, sign, ovf, in_ready3, out_valid3, sign3, ovf3;
  logic [19:0] bcd;
  logic [11:0] bcd3;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  bcd_seq_converter #(.BIN_W(16), .DIGITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .binary(binary),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .sign(sign), .ovf(ovf));
  bcd_seq_converter #(.BIN_W(16), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3), .binary(binary),
    .out_valid(out_valid3), .out_ready(out_ready), .bcd(bcd3), .sign(sign3), .ovf(ovf3));
  function automatic logic [39:0] to_bcd(longint unsigned v);
    logic [39:0] r;
    for (int i = 0; i < 10; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic longint unsigned magof(logic [15:0] b);
`ifdef BCD_SIGNED_EN
    return b[15] ? 65536 - longint'(b) : longint'(b);
`else
    return longint'(b);
`endif
  endfunction
  function automatic logic sgnof(logic [15:0] b);
`ifdef BCD_SIGNED_EN
    return b[15];
`else
    return 1'b0;
`endif
  endfunction
  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // protocol-level model: 0 idle, 1 converting, 2 result presented
  int m_st = 0, m_cnt = 0;
  logic [19:0] e_bcd = 0, p_bcd = 0;
  logic [11:0] e_bcd3 = 0, p_bcd3 = 0;
  logic e_sgn = 0, p_sgn = 0, e_ovf = 0, p_ovf = 0, e_ovf3 = 0, p_ovf3 = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 0; m_cnt <= 0;
      e_bcd <= 0; e_bcd3 <= 0; e_sgn <= 0; e_ovf <= 0; e_ovf3 <= 0;
    end else if (m_st == 0) begin
      if (in_valid) begin
        m_st   <= 1;
        m_cnt  <= 0;
        p_bcd  <= 20'(to_bcd(magof(binary) % 100000));
        p_ovf  <= magof(binary) >= 100000;
        p_bcd3 <= 12'(to_bcd(magof(binary) % 1000));
        p_ovf3 <= magof(binary) >= 1000;
        p_sgn  <= sgnof(binary);
      end
    end else if (m_st == 1) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == LAT) begin
        m_st <= 2;
        e_bcd <= p_bcd; e_bcd3 <= p_bcd3; e_sgn <= p_sgn; e_ovf <= p_ovf; e_ovf3 <= p_ovf3;
      end
    end else if (out_ready) m_st <= 0;
  end
  always @(negedge clk) begin
    chk("in_ready", in_ready, m_st == 0);
    chk("out_valid", out_valid, m_st == 2);
    chk("bcd", bcd, e_bcd);
    chk("sign", sign, e_sgn);
    chk("ovf", ovf, e_ovf);
    chk("in_ready3", in_ready3, m_st == 0);
    chk("out_valid3", out_valid3, m_st == 2);
    chk("bcd3", bcd3, e_bcd3);
    chk("sign3", sign3, e_sgn);
    chk("ovf3", ovf3, e_ovf3);
  end
  logic [19:0] r;
  logic [11:0] r3;
  logic o, o3, s;
  task automatic conv(input logic [15:0] v, input int hold);
    int n, lat;
    in_valid = 1; binary = v; n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #2; n++; end
    chk("accept_wait", n < 50, 1);
    @(posedge clk); #2;
    lat = 0;
    while (!out_valid && lat < 60) begin
      in_valid = 1'($urandom); binary = 16'($urandom); out_ready = 1'($urandom);
      @(posedge clk); #2; lat++;
    end
    in_valid = 0; out_ready = 0;
    chk("latency", lat, LAT);
    r = bcd; r3 = bcd3; o = ovf; o3 = ovf3; s = sign;
    repeat (hold) @(posedge clk);
    #2 out_ready = 1;
    @(posedge clk); #2 out_ready = 0;
  endtask
  initial begin
    #1_000_000 $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
`ifdef BCD_SIGNED_EN
    conv(16'h8000, 0); chk("s8000_sign", s, 1); chk("s8000_bcd", r, 'h32768);
    conv(16'hFFFF, 1); chk("sFFFF_sign", s, 1); chk("sFFFF_bcd", r, 'h00001);
    conv(16'h0005, 0); chk("s0005_sign", s, 0); chk("s0005_bcd", r, 'h00005);
`else
    conv(16'hFFFF, 0); chk("FFFF_bcd", r, 'h65535); chk("FFFF_ovf", o, 0);
    chk("FFFF_bcd3", r3, 'h535); chk("FFFF_ovf3", o3, 1);
`endif
    conv(16'd0, 0); chk("zero_bcd", r, 'h00000); chk("zero_ovf", o, 0);
    conv(16'd9999, 0); chk("9999_bcd", r, 'h09999);
    conv(16'd1234, 0); chk("1234_bcd3", r3, 'h234); chk("1234_ovf3", o3, 1);
    conv(16'd999, 0); chk("999_bcd3", r3, 'h999); chk("999_ovf3", o3, 0);
    conv(16'd777, 5);
    conv(16'd1, 0); chk("b2b1_bcd", r, 'h00001);
    conv(16'd2, 0); chk("b2b2_bcd", r, 'h00002);
    in_valid = 1; binary = 16'd555;
    @(posedge clk); #2 in_valid = 0;
    repeat (8) @(posedge clk);
    #2 rst_n = 0;
    #1 chk("rst_out_valid", out_valid, 0); chk("rst_bcd", bcd, 0); chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #2 rst_n = 1;
    conv(16'd42, 0); chk("42_bcd", r, 'h00042);
    for (int i = 0; i < 150; i++)
      conv(($urandom % 3 == 0) ? 16'($urandom_range(990, 1010)) : 16'($urandom), $urandom % 4);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bcd_seq_converter.md
BCD_SEQ_CONVERTER -- requirements
Module: bcd_seq_converter

Interface
REQ-001 Parameter BIN_W, default 16: width of the binary input; legal range 4..32.
REQ-002 Parameter DIGITS, default 5: number of BCD output digits; legal range 1..10.
REQ-003 clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 in_valid  input  1: binary holds a value to convert.
REQ-006 in_ready  output  1: block accepts a new value.
REQ-007 binary  input  BIN_W: value to convert; sampled only on accept.
REQ-008 out_valid  output  1: bcd, sign and ovf hold a completed result.
REQ-009 out_ready  input  1: consumer takes the result.
REQ-010 bcd  output  4*DIGITS: packed BCD result; digit k occupies bits [4k+3:4k], and digit 0 is the ones digit.
REQ-011 sign  output  1: result is negative; only meaningful with BCD_SIGNED_EN defined.
REQ-012 ovf  output  1: the magnitude does not fit in DIGITS digits.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-014 IDLE: in_ready=1; on in_valid&&in_ready, latch the magnitude into the shift register, clear all digits and ovf, load the bit counter with BIN_W, and go to SHIFT.
REQ-015 SHIFT: each cycle, add 3 to every digit >=5, then shift {digits, shift register} left by one bit; decrement the counter.
- in_ready=0 and out_valid=0 throughout SHIFT.
REQ-016 The bit shifted out of the top digit SHALL be ORed into ovf, which is sticky for the conversion.
REQ-017 When the counter reaches 0, the FSM SHALL move to DONE.
- Latency: out_valid rises exactly BIN_W+1 cycles after the accept edge.
REQ-018 Result values:
- bcd = magnitude mod 10^DIGITS.
- ovf = 1 iff magnitude >= 10^DIGITS.
REQ-019 DONE: out_valid=1, and bcd, sign and ovf SHALL hold stable until out_valid&&out_ready.
- On that handshake, go to IDLE; in_ready rises on the next cycle.
- No new value is accepted in the same cycle as the handshake.
REQ-020 in_valid and binary changes while not in IDLE SHALL be ignored.
REQ-021 bcd, sign and ovf SHALL keep their last result values in IDLE and SHIFT, and update only on the entry to DONE.
REQ-022 The digit values presented in DONE SHALL each be 0..9.

Reset
REQ-023 While rst_n=0, regardless of clk:
- FSM = IDLE, so in_ready=1 and out_valid=0.
- bcd=0, sign=0, ovf=0; counter and shift register cleared.
REQ-024 Reset asserted during SHIFT or DONE SHALL abort the conversion; no partial result is ever presented.
REQ-025 After rst_n deasserts, the first accept SHALL be possible on the first rising edge of clk.

Configuration
REQ-026 With BCD_SIGNED_EN defined:
- binary is two's complement; on accept, sign = MSB and the magnitude = absolute value, as a BIN_W-bit unsigned value.
- The most negative input SHALL convert correctly (for example 0x8000 gives 32768).
REQ-027 With BCD_SIGNED_EN undefined:
- binary is unsigned, the magnitude = binary, and sign is tied to 0.
- Latency and the handshake SHALL be identical in both builds.

Verification
REQ-028 BIN_W=16, DIGITS=5, unsigned: accept 0xFFFF -> out_valid 17 cycles later, bcd=0x65535, ovf=0.
REQ-029 Accept 0x0000 -> bcd=0x00000, ovf=0; then 9999 -> bcd=0x09999.
REQ-030 DIGITS=3: accept 1234 -> bcd=0x234, ovf=1; accept 999 -> bcd=0x999, ovf=0.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; then raise out_ready -> in_ready=1 on the next cycle, and back-to-back conversions 1 and 2 both complete correctly.
REQ-032 Assert rst_n=0 at cycle 8 of SHIFT -> out_valid=0, bcd=0 and in_ready=1 at once; a new accept of 42 -> bcd=0x00042.
REQ-033 BCD_SIGNED_EN defined: 0x8000 -> sign=1, bcd=0x32768; 0xFFFF -> sign=1, bcd=0x00001; 0x0005 -> sign=0, bcd=0x00005.
